// File: rtl/uart_cmd_parser.sv
// ASCII command parser between the UART receiver/transmitter and the four display registers.
// Define UART_CMD_READALL_EN to add the "A" read-all command and grow the reply queue to 9 bytes.
module uart_cmd_parser #(
  parameter int TIMEOUT = 5000000,
  parameter int TO_W    = 23
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_send,
  output logic [7:0] tx_data,
  output logic [7:0] reg0,
  output logic [7:0] reg1,
  output logic [7:0] reg2,
  output logic [7:0] reg3,
  output logic       cmd_err,
  output logic       rx_ovr
);

`ifdef UART_CMD_READALL_EN
  localparam int QD = 9;
`else
  localparam int QD = 3;
`endif

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_IDX = 3'd1,
    S_GET_HI  = 3'd2,
    S_GET_LO  = 3'd3,
    S_GET_EOL = 3'd4,
    S_FLUSH   = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CMD_W = 2'd0,
    CMD_R = 2'd1,
    CMD_A = 2'd2
  } cmd_t;

  // {valid, nibble} decode of an ASCII hex digit
  function automatic logic [4:0] hex_dec(input logic [7:0] b);
    logic [4:0] r;
    if ((b >= 8'h30) && (b <= 8'h39)) begin
      r = {1'b1, b[3:0]};
    end else if (((b >= 8'h41) && (b <= 8'h46)) || ((b >= 8'h61) && (b <= 8'h66))) begin
      r = {1'b1, b[3:0] + 4'd9};
    end else begin
      r = 5'h00;
    end
    return r;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = {4'h3, n};
    end else begin
      c = {4'h4, n - 4'd9};
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      regs_q [4];
  logic [7:0]      regs_d [4];
  logic [7:0]      q_q [QD];
  logic [7:0]      q_d [QD];
  logic [3:0]      q_cnt_q, q_cnt_d;
  logic            tx_send_q, tx_send_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            guard_q, guard_d;
  logic            cmd_err_q, cmd_err_d;
  logic            rx_ovr_q, rx_ovr_d;

  logic       rx_eol_s;
  logic       rx_idx_s;
  logic [4:0] rx_hex_s;
  logic       parse_s;

  assign rx_eol_s = (rx_data == CH_CR) || (rx_data == CH_LF);
  assign rx_idx_s = (rx_data >= 8'h30) && (rx_data <= 8'h33);
  assign rx_hex_s = hex_dec(rx_data);
  assign parse_s  = (state_q != S_IDLE) && (state_q != S_RESP);

  // Next-state, reply queue and output computation
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    regs_d    = regs_q;
    q_d       = q_q;
    q_cnt_d   = q_cnt_q;
    tx_data_d = tx_data_q;
    guard_d   = tx_send_q;
    cmd_err_d = 1'b0;
    rx_ovr_d  = rx_ovr_q;

    if (parse_s && !rx_valid) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end else begin
      to_cnt_d = {TO_W{1'b0}};
    end

    // Skip the send cycle and the one after it so a late busy from the transmitter is honoured
    if (tx_ready && (q_cnt_q != 4'd0) && !tx_send_q && !guard_q) begin
      tx_send_d = 1'b1;
      tx_data_d = q_q[0];
      for (int i = 0; i < QD - 1; i++) begin
        q_d[i] = q_q[i + 1];
      end
      q_d[QD - 1] = 8'h00;
      q_cnt_d     = q_cnt_q - 4'd1;
    end else begin
      tx_send_d = 1'b0;
    end

    if (parse_s && !rx_valid && (to_cnt_q == TO_LIM)) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && !rx_eol_s) begin
          if (rx_data == 8'h57) begin
            cmd_d   = CMD_W;
            state_d = S_GET_IDX;
          end else if (rx_data == 8'h52) begin
            cmd_d   = CMD_R;
            state_d = S_GET_IDX;
`ifdef UART_CMD_READALL_EN
          end else if (rx_data == 8'h41) begin
            cmd_d   = CMD_A;
            state_d = S_GET_EOL;
`endif
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GET_IDX: begin
        if (rx_valid) begin
          if (rx_idx_s) begin
            idx_d   = rx_data[1:0];
            state_d = (cmd_q == CMD_W) ? S_GET_HI : S_GET_EOL;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_GET_HI, S_GET_LO: begin
        if (rx_valid) begin
          if (rx_hex_s[4] && (state_q == S_GET_HI)) begin
            wdata_d = {rx_hex_s[3:0], wdata_q[3:0]};
            state_d = S_GET_LO;
          end else if (rx_hex_s[4]) begin
            wdata_d = {wdata_q[7:4], rx_hex_s[3:0]};
            state_d = S_GET_EOL;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          wdata_d = wdata_q;
        end
      end
      S_GET_EOL: begin
        if (rx_valid && rx_eol_s) begin
          state_d = S_RESP;
          case (cmd_q)
            CMD_W: begin
              regs_d[idx_q] = wdata_q;
              q_d[0]        = 8'h4B;
              q_d[1]        = CH_LF;
              q_cnt_d       = 4'd2;
            end
            CMD_R: begin
              q_d[0]  = hex_chr(regs_q[idx_q][7:4]);
              q_d[1]  = hex_chr(regs_q[idx_q][3:0]);
              q_d[2]  = CH_LF;
              q_cnt_d = 4'd3;
            end
`ifdef UART_CMD_READALL_EN
            CMD_A: begin
              q_d[0]  = hex_chr(regs_q[3][7:4]);
              q_d[1]  = hex_chr(regs_q[3][3:0]);
              q_d[2]  = hex_chr(regs_q[2][7:4]);
              q_d[3]  = hex_chr(regs_q[2][3:0]);
              q_d[4]  = hex_chr(regs_q[1][7:4]);
              q_d[5]  = hex_chr(regs_q[1][3:0]);
              q_d[6]  = hex_chr(regs_q[0][7:4]);
              q_d[7]  = hex_chr(regs_q[0][3:0]);
              q_d[8]  = CH_LF;
              q_cnt_d = 4'd9;
            end
`endif
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else if (rx_valid) begin
          state_d = S_FLUSH;
        end else begin
          cmd_d = cmd_q;
        end
      end
      S_FLUSH: begin
        if (rx_valid && rx_eol_s) begin
          q_d[0]    = 8'h45;
          q_d[1]    = CH_LF;
          q_cnt_d   = 4'd2;
          cmd_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cmd_err_d = 1'b0;
        end
      end
      S_RESP: begin
        if (rx_valid) begin
          rx_ovr_d = 1'b1;
        end else begin
          rx_ovr_d = rx_ovr_q;
        end
        if (q_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_W;
      idx_q     <= 2'd0;
      wdata_q   <= 8'h00;
      to_cnt_q  <= {TO_W{1'b0}};
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'h00;
      end
      for (int i = 0; i < QD; i++) begin
        q_q[i] <= 8'h00;
      end
      q_cnt_q   <= 4'd0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
      guard_q   <= 1'b0;
      cmd_err_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      to_cnt_q  <= to_cnt_d;
      regs_q    <= regs_d;
      q_q       <= q_d;
      q_cnt_q   <= q_cnt_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      guard_q   <= guard_d;
      cmd_err_q <= cmd_err_d;
      rx_ovr_q  <= rx_ovr_d;
    end
  end

  assign tx_send = tx_send_q;
  assign tx_data = tx_data_q;
  assign reg0    = regs_q[0];
  assign reg1    = regs_q[1];
  assign reg2    = regs_q[2];
  assign reg3    = regs_q[3];
  assign cmd_err = cmd_err_q;
  assign rx_ovr  = rx_ovr_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized self-checking bench for uart_cmd_parser against a line-level command model.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  localparam int TO  = 200;
  localparam int TOW = 8;

  typedef logic [7:0] bq_t[$];

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic       tx_send;
  logic [7:0] tx_data;
  logic [7:0] reg0, reg1, reg2, reg3;
  logic       cmd_err;
  logic       rx_ovr;

  int   n_tests = 0;
  int   n_fail = 0;
  bq_t  got_q;
  int   err_cnt = 0;
  int   exp_err = 0;
  int   hs_viol = 0;
  int   lat_viol = 0;
  int   rdy_mode = 0;
  int   busy = 0;
  time  eol_t = 0;
  logic [7:0] m_regs [4];

  always #10 sys_clk = ~sys_clk;

  uart_cmd_parser #(.TIMEOUT(TO), .TO_W(TOW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_send(tx_send), .tx_data(tx_data),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .cmd_err(cmd_err), .rx_ovr(rx_ovr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model and output monitor
  initial forever begin
    @(negedge sys_clk);
    if (tx_send) begin
      got_q.push_back(tx_data);
      if (!tx_ready) hs_viol++;
      if ($time < eol_t + 40) lat_viol++;
      busy = $urandom_range(4, 1);
    end
    if (cmd_err) err_cnt++;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: begin
        if (busy > 0) begin
          busy--;
          tx_ready = 1'b0;
        end else begin
          tx_ready = ($urandom_range(3, 0) != 0);
        end
      end
      default: tx_ready = 1'b0;
    endcase
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit is_hx(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic int hv(input logic [7:0] c);
    if (c <= 8'h39) return int'(c) - 48;
    else if (c <= 8'h46) return int'(c) - 55;
    else return int'(c) - 87;
  endfunction

  function automatic logic [7:0] hc(input int n);
    string hd = "0123456789ABCDEF";
    return hd[n];
  endfunction

  function automatic bq_t line_q(input string s, input logic [7:0] eol);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(eol);
    return q;
  endfunction

  // Reply expected for one command line (bytes before the terminating EOL)
  task automatic model_line(input bq_t line, output bq_t rep);
    int idx;
    rep = {};
    idx = (line.size() > 1) ? int'(line[1]) - 48 : -1;
    if (line.size() == 0) begin
      rep = {};
    end else if (line.size() == 4 && line[0] == 8'h57 && idx >= 0 && idx <= 3 &&
                 is_hx(line[2]) && is_hx(line[3])) begin
      m_regs[idx] = 8'(hv(line[2]) * 16 + hv(line[3]));
      rep = {8'h4B, 8'h0A};
    end else if (line.size() == 2 && line[0] == 8'h52 && idx >= 0 && idx <= 3) begin
      rep = {hc(m_regs[idx] / 16), hc(m_regs[idx] % 16), 8'h0A};
    end
`ifdef UART_CMD_READALL_EN
    else if (line.size() == 1 && line[0] == 8'h41) begin
      for (int r = 3; r >= 0; r--) begin
        rep.push_back(hc(m_regs[r] / 16));
        rep.push_back(hc(m_regs[r] % 16));
      end
      rep.push_back(8'h0A);
    end
`endif
    else begin
      rep = {8'h45, 8'h0A};
      exp_err++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge sys_clk);
    rx_valid = 1'b1;
    rx_data  = b;
    if (b == 8'h0D || b == 8'h0A) eol_t = $time;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic check_regs(input string tag);
    check_val(tag, {reg3, reg2, reg1, reg0}, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
  endtask

  task automatic expect_reply(input bq_t exp, input int budget);
    int k = 0;
    while (got_q.size() < exp.size() && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (12) @(negedge sys_clk);
    check_val("reply_len", got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check_val("reply_byte", (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD, {24'h0, exp[i]});
    check_val("cmd_err_cnt", err_cnt, exp_err);
    check_regs("regs");
  endtask

  task automatic run_cmd(input bq_t c, input int gap_lo, input int gap_hi);
    bq_t line, rep;
    bit started = 1'b0, done = 1'b0;
    got_q.delete();
    foreach (c[i]) send_byte(c[i], $urandom_range(gap_hi, gap_lo));
    foreach (c[i]) begin
      if (c[i] == 8'h0D || c[i] == 8'h0A) begin
        if (started) done = 1'b1;
      end else if (!done) begin
        line.push_back(c[i]);
        started = 1'b1;
      end
    end
    model_line(line, rep);
    expect_reply(rep, 3000);
  endtask

  initial begin
    bq_t rep, c;
    int k, n0, t;
    logic [7:0] idx, h1, h2, eol;
    string hx = "0123456789ABCDEFabcdef";
    string bad = "4579Z";
    string bh = "Gg/:@";
    string jk = "XwrQ0";

    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    repeat (3) @(negedge sys_clk);
    check_val("rst_ctl", {21'h0, tx_send, cmd_err, rx_ovr, tx_data}, 32'h0);
    check_regs("rst_regs");
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_val("idle_ctl", {21'h0, tx_send, cmd_err, rx_ovr, tx_data}, 32'h0);

    // Write latency: register changes one cycle after the LF strobe
    got_q.delete();
    send_byte(8'h57, 1); send_byte(8'h32, 0); send_byte(8'h41, 2);
    send_byte(8'h35, 0);
    @(negedge sys_clk);
    rx_valid = 1'b1; rx_data = 8'h0A; eol_t = $time;
    check_val("w_before", {24'h0, reg2}, 32'h0);
    @(negedge sys_clk);
    rx_valid = 1'b0;
    check_val("w_after", {24'h0, reg2}, 32'hA5);
    model_line({8'h57, 8'h32, 8'h41, 8'h35}, rep);
    expect_reply(rep, 500);

    // CR terminates, the trailing LF is ignored, then read back
    run_cmd(line_q("W1c3", 8'h0D), 0, 2);
    run_cmd(line_q("", 8'h0A), 0, 0);
    run_cmd(line_q("R1", 8'h0A), 0, 2);
    run_cmd(line_q("W5FF", 8'h0A), 0, 2);
    run_cmd(line_q("X", 8'h0A), 0, 2);

    // Partial command dropped after the idle timeout, then just under it
    got_q.delete();
    send_byte(8'h57, 0); send_byte(8'h30, 0);
    repeat (TO + 20) @(negedge sys_clk);
    check_val("to_silent", got_q.size(), 0);
    run_cmd(line_q("R0", 8'h0A), 0, 2);
    run_cmd(line_q("W37E", 8'h0A), TO - 20, TO - 20);

    run_cmd(line_q("W012", 8'h0A), 0, 1);
    run_cmd(line_q("W134", 8'h0A), 0, 1);
    run_cmd(line_q("W256", 8'h0A), 0, 1);
    run_cmd(line_q("W378", 8'h0A), 0, 1);
    run_cmd(line_q("A", 8'h0A), 0, 1);

    // Transmitter stalled, byte injected mid-reply
    rdy_mode = 2;
    repeat (2) @(negedge sys_clk);
    got_q.delete();
    send_byte(8'h52, 0); send_byte(8'h33, 0); send_byte(8'h0A, 0);
    model_line({8'h52, 8'h33}, rep);
    repeat (500) @(negedge sys_clk);
    check_val("ovr_pre", {31'h0, rx_ovr}, 32'h0);
    send_byte(8'h5A, 0);
    repeat (500) @(negedge sys_clk);
    check_val("stall_no_tx", got_q.size(), 0);
    check_val("ovr_set", {31'h0, rx_ovr}, 32'h1);
    rdy_mode = 1;
    expect_reply(rep, 500);
    check_val("ovr_sticky", {31'h0, rx_ovr}, 32'h1);
    run_cmd(line_q("R3", 8'h0A), 0, 2);

    // Reset in the middle of a reply
    got_q.delete();
    send_byte(8'h52, 0); send_byte(8'h33, 0); send_byte(8'h0A, 0);
    k = 0;
    while (got_q.size() < 1 && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    check_val("rst_mid_started", got_q.size(), 1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    check_val("rst_mid_ctl", {21'h0, tx_send, cmd_err, rx_ovr, tx_data}, 32'h0);
    check_regs("rst_mid_regs");
    n0 = got_q.size();
    repeat (30) @(negedge sys_clk);
    check_val("rst_mid_quiet", got_q.size(), n0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    run_cmd(line_q("R3", 8'h0A), 0, 2);

    // Randomized command mix
    for (int n = 0; n < 40; n++) begin
      rdy_mode = $urandom_range(1, 0);
      t   = $urandom_range(7, 0);
      idx = 8'h30 + 8'($urandom_range(3, 0));
      h1  = hx[$urandom_range(21, 0)];
      h2  = hx[$urandom_range(21, 0)];
      eol = ($urandom_range(1, 0) != 0) ? 8'h0D : 8'h0A;
      case (t)
        0, 1: c = {8'h57, idx, h1, h2};
        2, 3: c = {8'h52, idx};
        4:    c = {8'h41};
        5:    c = {(($urandom_range(1, 0) != 0) ? 8'h57 : 8'h52), bad[$urandom_range(4, 0)], h1, h2};
        6:    c = {8'h57, idx, bh[$urandom_range(4, 0)], h2};
        default: c = {jk[$urandom_range(4, 0)], h1};
      endcase
      c.push_back(eol);
      run_cmd(c, 0, 3);
      if (eol == 8'h0D && $urandom_range(1, 0) != 0) run_cmd(line_q("", 8'h0A), 0, 0);
    end

    check_val("tx_ready_handshake", hs_viol, 0);
    check_val("tx_first_latency", lat_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
